// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: op codes, register widths,
// FSM state encoding and small op-classification helpers.
package mem_stage_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;

  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic [RegBus-1:0]     ZeroWord   = '0;

  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LBU  = 4'd2;
  localparam logic [3:0] MEM_OP_LH   = 4'd3;
  localparam logic [3:0] MEM_OP_LHU  = 4'd4;
  localparam logic [3:0] MEM_OP_LW   = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
           (op == MEM_OP_LHU) || (op == MEM_OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    return (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return (op == MEM_OP_LW) || (op == MEM_OP_SW);
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    return (is_half(op) && a[0]) || (is_word(op) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-outstanding req/ack data bus between the MEM stage (master) and
// data memory (slave).
interface mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W/8-1:0]   bus_sel;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_ack;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_lane_extract.sv
// Picks the addressed byte/halfword out of a 32-bit read word and
// sign- or zero-extends it according to the load op.
module mem_lane_extract
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  op,
  output logic [31:0] load_val
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rdata[{addr_lo, 3'b000} +: 8];
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_val  = ZeroWord;
    case (op)
      MEM_OP_LB:  load_val = {{24{lane_byte[7]}}, lane_byte};
      MEM_OP_LBU: load_val = {24'd0, lane_byte};
      MEM_OP_LH:  load_val = {{16{lane_half[15]}}, lane_half};
      MEM_OP_LHU: load_val = {16'd0, lane_half};
      MEM_OP_LW:  load_val = rdata;
      default:    load_val = ZeroWord;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one bus transfer per load/store, stalls the
// pipeline while it is in flight, and passes non-memory ops straight through.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [3:0]            mem_op,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_reg2,
  output logic [RegAddrBus-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [DATA_W-1:0]     wb_wdata,
  output logic                  misalign,
  output logic                  stallreq,
  mem_stage_if.master           bus
);

  state_e              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]          bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   cap_q, cap_d;

  logic [DATA_W-1:0]   load_val;
  logic                op_is_mem;
  logic                op_misaligned;
  logic [3:0]          sel_calc;
  logic [DATA_W-1:0]   wdata_calc;
  logic                unused_stall_bits;

  assign unused_stall_bits = ^{stall[5:4], stall[2:0]};

  mem_lane_extract u_extract (
    .rdata    (bus.bus_rdata),
    .addr_lo  (mem_addr[1:0]),
    .op       (mem_op),
    .load_val (load_val)
  );

  always_comb begin
    op_is_mem     = is_load(mem_op) || is_store(mem_op);
    op_misaligned = op_is_mem && misaligned(mem_op, mem_addr[1:0]);
    if (is_word(mem_op)) begin
      sel_calc   = 4'b1111;
      wdata_calc = mem_reg2;
    end else if (is_half(mem_op)) begin
      sel_calc   = 4'b0011 << mem_addr[1:0];
      wdata_calc = {2{mem_reg2[15:0]}};
    end else begin
      sel_calc   = 4'b0001 << mem_addr[1:0];
      wdata_calc = {4{mem_reg2[7:0]}};
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    cap_d       = cap_q;
    wb_wd       = mem_wd;
    wb_wreg     = mem_wreg;
    wb_wdata    = mem_wdata;
    misalign    = 1'b0;
    stallreq    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_misaligned) begin
          misalign = 1'b1;
          wb_wreg  = 1'b0;
        end else if (op_is_mem) begin
          stallreq    = 1'b1;
          wb_wreg     = 1'b0;
          wb_wdata    = ZeroWord;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store(mem_op);
          bus_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
          bus_sel_d   = sel_calc;
          bus_wdata_d = wdata_calc;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stallreq = 1'b1;
        wb_wreg  = 1'b0;
        wb_wdata = ZeroWord;
        if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          if (is_load(mem_op)) cap_d = load_val;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // EX/MEM still holds this op, so mem_op tells load from store here.
        wb_wdata = cap_q;
        wb_wreg  = is_load(mem_op) ? mem_wreg : 1'b0;
        if (!stall[3]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      cap_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      cap_q       <= cap_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_sel   = bus_sel_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule
